// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

   localparam int RESET_ZERO  = 0;
   localparam int RESET_INDEX = 1;
   localparam int MAX_BUS_W   = 128;

   // Extract read port k from a packed address bus; callers cast the result to ADDR_W bits.
   function automatic logic [31:0] unpack_addr(input logic [MAX_BUS_W-1:0] bus,
                                               input int k,
                                               input int addr_w);
      logic [MAX_BUS_W-1:0] shifted;
      shifted = bus >> (k * addr_w);
      return shifted[31:0] & ((32'd1 << addr_w) - 32'd1);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits, incrementally tracked pending count and
// read-port pending qualification for the multi-port register file.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_pend,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;
   logic             rsv_ok;
   logic             set_new;
   logic             clr0;
   logic             clr1;

   // A reservation wins over a same-cycle write: it belongs to a newer producer.
   always_comb begin
      rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
      pend_d = pend_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (rsv_ok && rsv_addr == ADDR_W'(i)) begin
            pend_d[i] = 1'b1;
         end else if ((wr0_en && wr0_addr == ADDR_W'(i)) ||
                      (wr1_en && wr1_addr == ADDR_W'(i))) begin
            pend_d[i] = 1'b0;
         end
      end

      set_new = rsv_ok && !pend_q[rsv_addr];
      clr0    = wr0_en && pend_q[wr0_addr] && !(rsv_ok && rsv_addr == wr0_addr);
      clr1    = wr1_en && pend_q[wr1_addr] && !(rsv_ok && rsv_addr == wr1_addr) &&
                !(wr0_en && wr0_addr == wr1_addr);
      pend_cnt_d = pend_cnt_q + {{ADDR_W{1'b0}}, set_new}
                              - {{ADDR_W{1'b0}}, clr0}
                              - {{ADDR_W{1'b0}}, clr1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // A value being bypassed this cycle is never reported as pending.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      rd_pend = '0;
      ra      = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = ADDR_W'(unpack_addr(MAX_BUS_W'(rd_addr), k, ADDR_W));
         rd_pend[k] = pend_q[ra] && !(wr0_en && wr0_addr == ra) &&
                      !(wr1_en && wr1_addr == ra);
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports with same-cycle write bypass, and a reservation scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int NUM_RD     = 2,
   parameter int RESET_MODE = 1,
   parameter int ZERO_REG   = 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pend,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wr0_ok;
   logic              wr1_ok;

   function automatic logic [DATA_W-1:0] reset_val(input int i);
      return (RESET_MODE == RESET_INDEX) ? DATA_W'(i) : '0;
   endfunction

   // Port 1 is applied last so it overrides port 0 on an address collision.
   always_comb begin
      wr0_ok = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
      wr1_ok = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);
      regs_d = regs_q;
      if (wr0_ok) regs_d[wr0_addr] = wr0_data;
      if (wr1_ok) regs_d[wr1_addr] = wr1_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= reset_val(i);
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] val;
      rd_data = '0;
      ra      = '0;
      val     = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = ADDR_W'(unpack_addr(MAX_BUS_W'(rd_addr), k, ADDR_W));
         if (ZERO_REG != 0 && ra == '0)       val = '0;
         else if (wr1_en && wr1_addr == ra)   val = wr1_data;
         else if (wr0_en && wr0_addr == ra)   val = wr0_data;
         else                                 val = regs_q[ra];
         rd_data[k*DATA_W +: DATA_W] = val;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd_addr  (rd_addr),
      .rd_pend  (rd_pend),
      .pend_cnt (pend_cnt)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int DEPTH  = 32;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_pend;
   logic                     wr0_en;
   logic [ADDR_W-1:0]        wr0_addr;
   logic [DATA_W-1:0]        wr0_data;
   logic                     wr1_en;
   logic [ADDR_W-1:0]        wr1_addr;
   logic [DATA_W-1:0]        wr1_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic [ADDR_W:0]          pend_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [DATA_W-1:0] m_reg  [DEPTH];
   bit                m_pend [DEPTH];

   regfile_mp #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .NUM_RD     (NUM_RD),
      .RESET_MODE (1),
      .ZERO_REG   (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_pend  (rd_pend),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .pend_cnt (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs just after the next rising edge.
   task automatic applyStimulus(input bit w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                input bit w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                input bit re, input logic [4:0] ra,
                                input logic [4:0] r0, input logic [4:0] r1);
      @(posedge clk);
      #1;
      wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
      wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
      rsv_en = re;  rsv_addr = ra;
      rd_addr = {r1, r0};
   endtask

   function automatic bool_write_hits(input logic [4:0] a);
      return (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0)                 return 32'd0;
      if (wr1_en && wr1_addr == a)   return wr1_data;
      if (wr0_en && wr0_addr == a)   return wr0_data;
      return m_reg[a];
   endfunction

   function automatic logic model_rd_pend(input logic [4:0] a);
      return m_pend[a] && !bool_write_hits(a);
   endfunction

   function automatic logic [31:0] model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
      return 32'(n);
   endfunction

   // Reference model: architectural register contents and the set of pending registers.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = 32'(i);
            m_pend[i] = 1'b0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (rsv_en && rsv_addr == 5'(i))  m_pend[i] = 1'b1;
            else if (bool_write_hits(5'(i)))  m_pend[i] = 1'b0;
         end
         if (wr0_en && wr0_addr != 5'd0) m_reg[wr0_addr] = wr0_data;
         if (wr1_en && wr1_addr != 5'd0) m_reg[wr1_addr] = wr1_data;
      end
   end

   // Every falling edge compares all outputs against the model for the current inputs.
   always @(negedge clk) begin
      logic [4:0] a;
      if (chk_en) begin
         for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            checkOutput($sformatf("model rd_data[%0d] addr %0d", k, a),
                        rd_data[k*DATA_W +: DATA_W], model_read(a));
            checkOutput($sformatf("model rd_pend[%0d] addr %0d", k, a),
                        32'(rd_pend[k]), 32'(model_rd_pend(a)));
         end
         checkOutput("model pend_cnt", 32'(pend_cnt), model_count());
      end
   end

   initial begin
      rst_n = 1'b1;
      wr0_en = 0; wr0_addr = 0; wr0_data = 0;
      wr1_en = 0; wr1_addr = 0; wr1_data = 0;
      rsv_en = 0; rsv_addr = 0;
      rd_addr = {5'd31, 5'd7};
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset rd_data port0 addr7", rd_data[31:0], 32'd7);
      checkOutput("reset rd_data port1 addr31", rd_data[63:32], 32'd31);
      checkOutput("reset rd_pend", 32'(rd_pend), 32'd0);
      checkOutput("reset pend_cnt", 32'(pend_cnt), 32'd0);
      rd_addr = {5'd31, 5'd0};
      #1;
      checkOutput("reset zero reg read", rd_data[31:0], 32'd0);
      #8 rst_n = 1'b1;
      chk_en = 1'b1;

      // Colliding writes: port 1 wins, both bypassed and stored.
      applyStimulus(1, 5, 32'hAAAA, 1, 5, 32'h5555, 0, 0, 5, 0);
      @(negedge clk) checkOutput("collide bypass", rd_data[31:0], 32'h5555);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
      @(negedge clk) checkOutput("collide stored", rd_data[31:0], 32'h5555);

      // Register 0 ignores writes and reservations.
      applyStimulus(1, 0, 32'hFFFF, 1, 0, 32'hFFFF, 0, 0, 0, 0);
      @(negedge clk) checkOutput("zero write bypass", rd_data[31:0], 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk) checkOutput("zero after write", rd_data[31:0], 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) checkOutput("zero rsv count", 32'(pend_cnt), 32'd0);

      // Reserve then write back register 9.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      @(negedge clk);
      checkOutput("rsv9 rd_pend", 32'(rd_pend[0]), 32'd1);
      checkOutput("rsv9 pend_cnt", 32'(pend_cnt), 32'd1);
      applyStimulus(1, 9, 32'h1234, 0, 0, 0, 0, 0, 9, 0);
      @(negedge clk);
      checkOutput("wb9 rd_pend", 32'(rd_pend[0]), 32'd0);
      checkOutput("wb9 rd_data", rd_data[31:0], 32'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      @(negedge clk) checkOutput("wb9 pend_cnt", 32'(pend_cnt), 32'd0);

      // Reserve and write register 12 together: written and still pending.
      applyStimulus(0, 0, 0, 1, 12, 32'h42, 1, 12, 12, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
      @(negedge clk);
      checkOutput("rsvwr12 rd_data", rd_data[31:0], 32'h42);
      checkOutput("rsvwr12 rd_pend", 32'(rd_pend[0]), 32'd1);
      checkOutput("rsvwr12 pend_cnt", 32'(pend_cnt), 32'd1);

      // Three reservations, then an asynchronous reset in the middle of the cycle.
      applyStimulus(1, 12, 32'h0, 0, 0, 0, 0, 0, 3, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 3, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 3, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      @(negedge clk) checkOutput("three rsv pend_cnt", 32'(pend_cnt), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset pend_cnt", 32'(pend_cnt), 32'd0);
      checkOutput("async reset reg3", rd_data[31:0], 32'd3);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Randomized traffic, biased toward low addresses to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] a [5];
         for (int j = 0; j < 5; j++)
            a[j] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         applyStimulus($urandom_range(0, 1) == 1, a[0], $urandom,
                       $urandom_range(0, 1) == 1, a[1], $urandom,
                       $urandom_range(0, 2) == 0, a[2], a[3], a[4]);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
